// File: rtl/miner_regs_pkg.sv
// miner_regs_pkg
//   Register map of the miner's 32-bit word-addressed Avalon-MM slave, the
//   bit layout of its CTL and STATUS words, and the job-master FSM states.
//   Shared by miner_job_master and its testbench.
package miner_regs_pkg;

   // Word addresses
   localparam logic [4:0] ADDR_SOLN  = 5'd0;   // solution[31:0]; [63:32] at +1
   localparam logic [4:0] ADDR_STAT  = 5'd2;
   localparam logic [4:0] ADDR_SHA3  = 5'd3;
   localparam logic [4:0] ADDR_HDR   = 5'd4;   // 8 words, MSW first
   localparam logic [4:0] ADDR_DIFF  = 5'd12;  // 8 words, MSW first
   localparam logic [4:0] ADDR_START = 5'd20;  // nonce[63:32], then nonce[31:0]
   localparam logic [4:0] ADDR_CTL   = 5'd22;  // reading it clears the IRQ

   // CTL bit positions
   localparam int CTL_RUN           = 0;
   localparam int CTL_TEST          = 1;
   localparam int CTL_HALT          = 2;
   localparam int CTL_PAD_LAST_LSB  = 16;
   localparam int CTL_PAD_FIRST_LSB = 24;

   // STATUS bit positions; bits 31:24 are unused by the slave, so the master
   // borrows bit 31 to flag a watchdog timeout in its result record.
   localparam int STAT_FOUND   = 0;
   localparam int STAT_RUNNING = 1;
   localparam int STAT_TESTING = 2;
   localparam int STAT_TIMEOUT = 31;

   typedef enum logic [3:0] {
      IDLE,
      WR_HDR,
      WR_DIFF,
      WR_NONCE,
      WR_RUN,
      WAIT_IRQ,
      RD,
      WR_STOP,
      RESULT
   } job_state_e;

   function automatic logic [31:0] ctl_word(input logic [7:0] pad_first,
                                            input logic [7:0] pad_last,
                                            input logic       test,
                                            input logic       halt,
                                            input logic       run);
      logic [31:0] w;
      w = '0;
      w[CTL_PAD_FIRST_LSB +: 8] = pad_first;
      w[CTL_PAD_LAST_LSB +: 8]  = pad_last;
      w[CTL_HALT]               = halt;
      w[CTL_TEST]               = test;
      w[CTL_RUN]                = run;
      return w;
   endfunction

endpackage

// File: rtl/miner_job_master.sv
// miner_job_master
//   Avalon-MM master that takes one mining job from a valid/ready stream,
//   programs the miner slave (header, difficulty, start nonce, CTL run),
//   waits for its IRQ, reads CTL/solution/status back, stops the core and
//   presents a result record on a valid/ready stream.
//
// Ports
//   clk, rst_n           bus clock (shared with the slave), async active-low reset
//   job_*                job stream in (header, difficulty, nonce, pads, test)
//   abort                level; cancels the job in progress with a halt write
//   res_*                result stream out (solution, status, found, aborted)
//   avm_*                Avalon-MM master: no waitrequest, read latency 1
//   irq                  slave IRQ, level until CTL is read
//
// Build option
//   MINER_JOB_MASTER_TIMEOUT_EN  adds a WAIT_IRQ watchdog of TIMEOUT_CYCLES;
//                                expiry takes the abort path with status[31]=1.
import miner_regs_pkg::*;

module miner_job_master #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd600_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [255:0] job_header,
   input  logic [255:0] job_difficulty,
   input  logic [63:0]  job_nonce,
   input  logic [7:0]   job_pad_first,
   input  logic [7:0]   job_pad_last,
   input  logic         job_test,
   input  logic         abort,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [63:0]  res_solution,
   output logic [31:0]  res_status,
   output logic         res_found,
   output logic         res_aborted,
   output logic [4:0]   avm_address,
   output logic         avm_read,
   output logic         avm_write,
   output logic [31:0]  avm_writedata,
   input  logic [31:0]  avm_readdata,
   input  logic         irq
);

   job_state_e   state;
   logic [2:0]   idx;
   logic [2:0]   idx_nxt;
   logic [255:0] hdr_q;
   logic [255:0] diff_q;
   logic [63:0]  nonce_q;
   logic [7:0]   pad_first_q;
   logic [7:0]   pad_last_q;
   logic         test_q;
   logic         aborted_q;
   logic         rd_vld_p1;
   logic [4:0]   rd_addr_p1;
   logic         abort_window;
   logic         timeout_hit;
   logic         halt_go;

   assign idx_nxt = idx + 3'd1;

   // Word i of a 256-bit field, most significant word first.
   function automatic logic [31:0] word_sel(input logic [255:0] v, input logic [2:0] i);
      logic [7:0] base;
      base = {3'd7 - i, 5'd0};
      return v[base +: 32];
   endfunction

   // Read-back order: CTL first (clears the IRQ), then solution low/high, status.
   function automatic logic [4:0] rd_addr_sel(input logic [2:0] i);
      case (i)
         3'd0:    return ADDR_CTL;
         3'd1:    return ADDR_SOLN;
         3'd2:    return ADDR_SOLN + 5'd1;
         default: return ADDR_STAT;
      endcase
   endfunction

`ifdef MINER_JOB_MASTER_TIMEOUT_EN
   logic [31:0] wait_cnt;

   // Held at zero outside WAIT_IRQ, so it reads 0 on the first WAIT_IRQ cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 wait_cnt <= '0;
      else if (state != WAIT_IRQ) wait_cnt <= '0;
      else                        wait_cnt <= wait_cnt + 32'd1;
   end

   // An IRQ in the final cycle still counts as a normal completion.
   assign timeout_hit = (state == WAIT_IRQ) && !irq && (wait_cnt == TIMEOUT_CYCLES - 32'd1);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   assign abort_window = (state inside {WR_HDR, WR_DIFF, WR_NONCE, WR_RUN, WAIT_IRQ, RD});
   assign halt_go      = abort_window && (abort || timeout_hit);
   assign res_found    = res_status[STAT_FOUND];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         hdr_q         <= '0;
         diff_q        <= '0;
         nonce_q       <= '0;
         pad_first_q   <= '0;
         pad_last_q    <= '0;
         test_q        <= 1'b0;
         aborted_q     <= 1'b0;
         rd_vld_p1     <= 1'b0;
         rd_addr_p1    <= '0;
         job_ready     <= 1'b0;
         res_valid     <= 1'b0;
         res_solution  <= '0;
         res_status    <= '0;
         res_aborted   <= 1'b0;
         avm_address   <= '0;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_writedata <= '0;
      end else begin
         // Strobes are single-cycle unless a state re-asserts them below.
         avm_read  <= 1'b0;
         avm_write <= 1'b0;

         // Stage p0 -> p1: remember which word a read asked for.
         rd_vld_p1  <= avm_read;
         rd_addr_p1 <= avm_address;

         // Stage p1 capture: readdata is valid one cycle after the read.
         // A halt drops any pending capture; the CTL read data is discarded.
         if (state == RD && rd_vld_p1 && !halt_go) begin
            if (rd_addr_p1 == ADDR_SOLN)             res_solution[31:0]  <= avm_readdata;
            else if (rd_addr_p1 == ADDR_SOLN + 5'd1) res_solution[63:32] <= avm_readdata;
            else if (rd_addr_p1 == ADDR_STAT)        res_status          <= avm_readdata;
         end

         if (halt_go) begin
            // The transfer on the bus this cycle completes; halt follows it.
            state         <= WR_STOP;
            aborted_q     <= 1'b1;
            res_solution  <= '0;
            res_status    <= '0;
            res_status[STAT_TIMEOUT] <= timeout_hit;
            avm_write     <= 1'b1;
            avm_address   <= ADDR_CTL;
            avm_writedata <= ctl_word(pad_first_q, pad_last_q, 1'b0, 1'b1, 1'b0);
         end else begin
            case (state)
               IDLE: begin
                  if (job_valid && job_ready) begin
                     job_ready     <= 1'b0;
                     hdr_q         <= job_header;
                     diff_q        <= job_difficulty;
                     nonce_q       <= job_nonce;
                     pad_first_q   <= job_pad_first;
                     pad_last_q    <= job_pad_last;
                     test_q        <= job_test;
                     aborted_q     <= 1'b0;
                     res_solution  <= '0;
                     res_status    <= '0;
                     res_aborted   <= 1'b0;
                     state         <= WR_HDR;
                     idx           <= '0;
                     avm_write     <= 1'b1;
                     avm_address   <= ADDR_HDR;
                     avm_writedata <= word_sel(job_header, 3'd0);
                  end else begin
                     job_ready <= 1'b1;
                  end
               end
               WR_HDR: begin
                  avm_write <= 1'b1;
                  if (idx == 3'd7) begin
                     state         <= WR_DIFF;
                     idx           <= '0;
                     avm_address   <= ADDR_DIFF;
                     avm_writedata <= word_sel(diff_q, 3'd0);
                  end else begin
                     idx           <= idx_nxt;
                     avm_address   <= ADDR_HDR + {2'b00, idx_nxt};
                     avm_writedata <= word_sel(hdr_q, idx_nxt);
                  end
               end
               WR_DIFF: begin
                  avm_write <= 1'b1;
                  if (idx == 3'd7) begin
                     state         <= WR_NONCE;
                     idx           <= '0;
                     avm_address   <= ADDR_START;
                     avm_writedata <= nonce_q[63:32];
                  end else begin
                     idx           <= idx_nxt;
                     avm_address   <= ADDR_DIFF + {2'b00, idx_nxt};
                     avm_writedata <= word_sel(diff_q, idx_nxt);
                  end
               end
               WR_NONCE: begin
                  avm_write <= 1'b1;
                  if (idx == 3'd0) begin
                     idx           <= idx_nxt;
                     avm_address   <= ADDR_START + 5'd1;
                     avm_writedata <= nonce_q[31:0];
                  end else begin
                     state         <= WR_RUN;
                     avm_address   <= ADDR_CTL;
                     avm_writedata <= ctl_word(pad_first_q, pad_last_q, test_q, 1'b0, 1'b1);
                  end
               end
               WR_RUN: state <= WAIT_IRQ;
               WAIT_IRQ: begin
                  if (irq) begin
                     state       <= RD;
                     idx         <= '0;
                     avm_read    <= 1'b1;
                     avm_address <= rd_addr_sel(3'd0);
                  end
               end
               RD: begin
                  // idx 0..3 are reads on the bus; idx 4 is the last capture cycle.
                  if (idx < 3'd3) begin
                     idx         <= idx_nxt;
                     avm_read    <= 1'b1;
                     avm_address <= rd_addr_sel(idx_nxt);
                  end else if (idx == 3'd3) begin
                     idx <= idx_nxt;
                  end else begin
                     state         <= WR_STOP;
                     avm_write     <= 1'b1;
                     avm_address   <= ADDR_CTL;
                     avm_writedata <= ctl_word(pad_first_q, pad_last_q, 1'b0, 1'b0, 1'b0);
                  end
               end
               WR_STOP: begin
                  state       <= RESULT;
                  res_valid   <= 1'b1;
                  res_aborted <= aborted_q;
               end
               RESULT: begin
                  if (res_ready) begin
                     res_valid <= 1'b0;
                     job_ready <= 1'b1;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_miner_job_master.sv
// tb_miner_job_master
//   Scoreboard bench for miner_job_master: a small slave model answers reads
//   and raises the IRQ after the run write; expected bus transfers and result
//   records are queued as each job is driven and popped as the DUT produces them.
//   Define MINER_JOB_MASTER_TIMEOUT_EN to include the watchdog scenario.
module tb_miner_job_master;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         job_valid;
   logic         job_ready;
   logic [255:0] job_header;
   logic [255:0] job_difficulty;
   logic [63:0]  job_nonce;
   logic [7:0]   job_pad_first;
   logic [7:0]   job_pad_last;
   logic         job_test;
   logic         abort;
   logic         res_valid;
   logic         res_ready;
   logic [63:0]  res_solution;
   logic [31:0]  res_status;
   logic         res_found;
   logic         res_aborted;
   logic [4:0]   avm_address;
   logic         avm_read;
   logic         avm_write;
   logic [31:0]  avm_writedata;
   logic [31:0]  avm_readdata;
   logic         irq;

   always #5 clk = ~clk;

   miner_job_master #(.TIMEOUT_CYCLES(32'd100)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_header    (job_header),
      .job_difficulty(job_difficulty),
      .job_nonce     (job_nonce),
      .job_pad_first (job_pad_first),
      .job_pad_last  (job_pad_last),
      .job_test      (job_test),
      .abort         (abort),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_solution  (res_solution),
      .res_status    (res_status),
      .res_found     (res_found),
      .res_aborted   (res_aborted),
      .avm_address   (avm_address),
      .avm_read      (avm_read),
      .avm_write     (avm_write),
      .avm_writedata (avm_writedata),
      .avm_readdata  (avm_readdata),
      .irq           (irq)
   );

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [31:0] data;
      int          gap;   // required cycles since previous transfer, 0 = any
   } xfer_t;

   typedef struct {
      logic [63:0] sol;
      logic [31:0] stat;
      logic        found;
      logic        aborted;
   } res_t;

   xfer_t bus_q[$];
   res_t  res_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   int    last_cyc = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- slave model ----------------
   logic        auto_irq;
   logic        tb_irq;
   logic        slave_irq;
   int          irq_at;
   logic [63:0] sol_val;
   logic [31:0] stat_val;
   logic [31:0] sregs [0:31];

   assign irq = slave_irq | tb_irq;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slave_irq    <= 1'b0;
         irq_at       <= -1;
         avm_readdata <= '0;
      end else begin
         avm_readdata <= '0;
         if (avm_write) begin
            sregs[avm_address] <= avm_writedata;
            if (avm_address == 5'd22 && avm_writedata[0] && auto_irq) irq_at <= cyc + 50;
         end
         if (avm_read) begin
            case (avm_address)
               5'd0:    avm_readdata <= sol_val[31:0];
               5'd1:    avm_readdata <= sol_val[63:32];
               5'd2:    avm_readdata <= stat_val;
               default: avm_readdata <= sregs[avm_address];
            endcase
            if (avm_address == 5'd22) slave_irq <= 1'b0;
         end
         if (cyc == irq_at) begin
            slave_irq <= 1'b1;
            irq_at    <= -1;
         end
      end
   end

   // ---------------- monitor ----------------
   xfer_t mon_e;
   res_t  mon_r;

   always @(negedge clk) begin
      if (rst_n) begin
         if (avm_read && avm_write) check("rd_wr_overlap", 64'd1, 64'd0);
         if (avm_read || avm_write) begin
            if (bus_q.size() == 0) begin
               check("bus_unexpected", {27'd0, avm_write, avm_read, avm_address}, 64'd0);
            end else begin
               mon_e = bus_q.pop_front();
               check("bus_kind", 64'(avm_write), 64'(mon_e.wr));
               check("bus_addr", 64'(avm_address), 64'(mon_e.addr));
               if (mon_e.wr) check("bus_data", 64'(avm_writedata), 64'(mon_e.data));
               if (mon_e.gap != 0) check("bus_gap", 64'(cyc - last_cyc), 64'(mon_e.gap));
            end
            last_cyc = cyc;
         end
         if (res_valid && res_ready) begin
            if (res_q.size() == 0) begin
               check("res_unexpected", 64'd1, 64'd0);
            end else begin
               mon_r = res_q.pop_front();
               check("res_solution", res_solution, mon_r.sol);
               check("res_status", 64'(res_status), 64'(mon_r.stat));
               check("res_found", 64'(res_found), 64'(mon_r.found));
               check("res_aborted", 64'(res_aborted), 64'(mon_r.aborted));
            end
         end
      end
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] ctl_exp(input logic [7:0] pf, input logic [7:0] pl,
                                           input logic tst, input logic halt, input logic run);
      return (32'(pf) << 24) | (32'(pl) << 16) | (32'(halt) << 2) | (32'(tst) << 1) | 32'(run);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [4:0] a, input logic [31:0] d, input int g);
      xfer_t e;
      e.wr = 1'b1; e.addr = a; e.data = d; e.gap = g;
      bus_q.push_back(e);
   endtask

   task automatic push_rd(input logic [4:0] a, input int g);
      xfer_t e;
      e.wr = 1'b0; e.addr = a; e.data = '0; e.gap = g;
      bus_q.push_back(e);
   endtask

   task automatic push_res(input logic [63:0] s, input logic [31:0] st, input logic f, input logic ab);
      res_t r;
      r.sol = s; r.stat = st; r.found = f; r.aborted = ab;
      res_q.push_back(r);
   endtask

   task automatic push_prog(input logic [255:0] hdr, input logic [255:0] diff, input logic [63:0] nonce,
                            input logic [7:0] pf, input logic [7:0] pl, input logic tst);
      for (int k = 0; k < 8; k++) push_wr(5'(4 + k), hdr[(7 - k) * 32 +: 32], (k == 0) ? 0 : 1);
      for (int k = 0; k < 8; k++) push_wr(5'(12 + k), diff[(7 - k) * 32 +: 32], 1);
      push_wr(5'd20, nonce[63:32], 1);
      push_wr(5'd21, nonce[31:0], 1);
      push_wr(5'd22, ctl_exp(pf, pl, tst, 1'b0, 1'b1), 1);
   endtask

   // Returns 1 ns after the handshake edge, i.e. inside the first header write.
   task automatic send_job(input logic [255:0] hdr, input logic [255:0] diff, input logic [63:0] nonce,
                           input logic [7:0] pf, input logic [7:0] pl, input logic tst);
      int n;
      job_header = hdr; job_difficulty = diff; job_nonce = nonce;
      job_pad_first = pf; job_pad_last = pl; job_test = tst;
      job_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!job_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!job_ready) check("job_accept_wait", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      job_valid = 1'b0;
   endtask

   task automatic wait_res(input int limit);
      int n;
      n = 0;
      @(negedge clk);
      while (!res_valid && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) check("res_wait", 64'd0, 64'd1);
   endtask

   // ---------------- stimulus ----------------
   logic [255:0] hdr;
   logic [255:0] diff;
   logic [63:0]  nonce;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; job_valid = 1'b0; job_header = '0; job_difficulty = '0; job_nonce = '0;
      job_pad_first = '0; job_pad_last = '0; job_test = 1'b0; abort = 1'b0; res_ready = 1'b0;
      auto_irq = 1'b0; tb_irq = 1'b0; sol_val = '0; stat_val = '0;

      repeat (3) @(negedge clk);
      check("rst_job_ready", 64'(job_ready), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_avm_strobes", {62'd0, avm_read, avm_write}, 64'd0);
      check("rst_avm_address", 64'(avm_address), 64'd0);
      check("rst_avm_writedata", 64'(avm_writedata), 64'd0);
      check("rst_res_solution", res_solution, 64'd0);
      check("rst_res_flags", {32'd0, res_status}, 64'd0);
      check("rst_res_bits", {62'd0, res_found, res_aborted}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Job 1: byte-ramp header, all-ones difficulty, normal completion.
      for (int i = 0; i < 32; i++) hdr[255 - 8 * i -: 8] = 8'(i);
      diff = '1;
      nonce = 64'h0000_0001_0000_0000;
      sol_val = 64'hDEAD_BEEF_CAFE_F00D;
      stat_val = 32'h0001_3C41;
      auto_irq = 1'b1;
      push_prog(hdr, diff, nonce, 8'h06, 8'h80, 1'b1);
      push_rd(5'd22, 0); push_rd(5'd0, 1); push_rd(5'd1, 1); push_rd(5'd2, 1);
      push_wr(5'd22, 32'h0680_0000, 2);
      push_res(64'hDEAD_BEEF_CAFE_F00D, 32'h0001_3C41, 1'b1, 1'b0);
      send_job(hdr, diff, nonce, 8'h06, 8'h80, 1'b1);
      wait_res(400);
      for (int i = 0; i < 10; i++) begin
         check("hold_res_valid", 64'(res_valid), 64'd1);
         check("hold_res_solution", res_solution, 64'hDEAD_BEEF_CAFE_F00D);
         check("hold_job_ready", 64'(job_ready), 64'd0);
         @(negedge clk);
      end
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      check("res_valid_dropped", 64'(res_valid), 64'd0);
      check("job_ready_back", 64'(job_ready), 64'd1);

      // abort in IDLE: no bus activity, job_ready stays up.
      abort = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("idle_abort_ready", 64'(job_ready), 64'd1);
      end
      @(posedge clk); #1 abort = 1'b0;

      // Job 2: abort during the 5th header write.
      auto_irq = 1'b0;
      for (int k = 0; k < 8; k++) hdr[k * 32 +: 32] = $urandom();
      for (int k = 0; k < 8; k++) diff[k * 32 +: 32] = $urandom();
      nonce = {$urandom(), $urandom()};
      for (int k = 0; k < 5; k++) push_wr(5'(4 + k), hdr[(7 - k) * 32 +: 32], (k == 0) ? 0 : 1);
      push_wr(5'd22, 32'h0680_0004, 1);
      push_res(64'd0, 32'd0, 1'b0, 1'b1);
      res_ready = 1'b1;
      send_job(hdr, diff, nonce, 8'h06, 8'h80, 1'b0);
      tick(4);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      wait_res(100);
      @(posedge clk); #1 res_ready = 1'b0;

      // Job 3: irq and abort in the same WAIT_IRQ cycle -> halt only.
      push_prog(hdr, diff, nonce, 8'h12, 8'h34, 1'b1);
      push_wr(5'd22, 32'h1234_0004, 7);
      push_res(64'd0, 32'd0, 1'b0, 1'b1);
      res_ready = 1'b1;
      send_job(hdr, diff, nonce, 8'h12, 8'h34, 1'b1);
      tick(24);
      tb_irq = 1'b1; abort = 1'b1;
      tick(1);
      tb_irq = 1'b0; abort = 1'b0;
      wait_res(100);
      @(posedge clk); #1 res_ready = 1'b0;

      // Job 4: second normal job, test off, solution not found.
      auto_irq = 1'b1;
      for (int k = 0; k < 8; k++) hdr[k * 32 +: 32] = $urandom();
      for (int k = 0; k < 8; k++) diff[k * 32 +: 32] = $urandom();
      nonce = {$urandom(), $urandom()};
      sol_val = {$urandom(), $urandom()};
      stat_val = 32'h0000_0006;
      push_prog(hdr, diff, nonce, 8'hAA, 8'h55, 1'b0);
      push_rd(5'd22, 0); push_rd(5'd0, 1); push_rd(5'd1, 1); push_rd(5'd2, 1);
      push_wr(5'd22, 32'hAA55_0000, 2);
      push_res(sol_val, 32'h0000_0006, 1'b0, 1'b0);
      res_ready = 1'b1;
      send_job(hdr, diff, nonce, 8'hAA, 8'h55, 1'b0);
      wait_res(400);
      @(posedge clk); #1 res_ready = 1'b0;

      // Asynchronous reset in the middle of the header writes.
      auto_irq = 1'b0;
      push_wr(5'd4, hdr[255:224], 0);
      push_wr(5'd5, hdr[223:192], 1);
      send_job(hdr, diff, nonce, 8'h01, 8'h02, 1'b0);
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_write_drop", 64'(avm_write), 64'd0);
      check("arst_job_ready", 64'(job_ready), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

`ifdef MINER_JOB_MASTER_TIMEOUT_EN
      // Watchdog: no IRQ, halt write 100 cycles after entering WAIT_IRQ.
      push_prog(hdr, diff, nonce, 8'h06, 8'h80, 1'b1);
      push_wr(5'd22, 32'h0680_0004, 101);
      push_res(64'd0, 32'h8000_0000, 1'b0, 1'b1);
      res_ready = 1'b1;
      send_job(hdr, diff, nonce, 8'h06, 8'h80, 1'b1);
      wait_res(400);
      @(posedge clk); #1 res_ready = 1'b0;
`endif

      tick(5);
      check("bus_q_left", 64'(bus_q.size()), 64'd0);
      check("res_q_left", 64'(res_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/miner_job_master.md
Name: miner_job_master

Overview:
- Avalon-MM master that drives the miner's 32-bit word-addressed register slave from a streaming job interface.
- Accepts one mining job and programs the slave: header, difficulty, start nonce, then control/run.
- Waits for the slave IRQ, reads back the solution and status, then stops the core and returns a result record.
- Sits between a job dispatcher (soft CPU replacement or test sequencer) and the miner slave, on the slave's clock.

Parameters:
- TIMEOUT_CYCLES, 32'd600_000_000: WAIT_IRQ watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  bus clock, the same clock as the miner slave
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  job accepted when valid&ready
- job_header  in  256  header hash
- job_difficulty  in  256  difficulty
- job_nonce  in  64  start nonce
- job_pad_first  in  8  padding first byte
- job_pad_last  in  8  padding last byte
- job_test  in  1  enable test mode
- abort  in  1  level; cancels the current job
- res_valid  out  1  result available
- res_ready  in  1  result consumed when valid&ready
- res_solution  out  64  solution nonce
- res_status  out  32  raw status word
- res_found  out  1  status bit 0
- res_aborted  out  1  job ended by abort or timeout
- avm_address  out  5  word address
- avm_read  out  1  read strobe, one cycle per word
- avm_write  out  1  write strobe, one cycle per word
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data, valid exactly 1 cycle after avm_read
- irq  in  1  slave IRQ, level until the CTL register (addr 22) is read

Behaviour:
- Reset values: all outputs 0, job_ready=0, FSM=IDLE, job and result registers cleared.
- Slave protocol: no waitrequest; fixed read latency 1; one transfer per cycle; read and write are never asserted together.
- FSM states: IDLE, WR_HDR, WR_DIFF, WR_NONCE, WR_RUN, WAIT_IRQ, RD, WR_STOP, RESULT.
- IDLE:
  - job_ready=1.
  - On handshake, latch all job fields and go to WR_HDR next cycle.
  - job_ready is 0 in every other state.
- WR_HDR: 8 consecutive writes, addr 4..11, data header[255:224] down to header[31:0].
- WR_DIFF: addr 12..19, same MSW-first order as the header.
- WR_NONCE: addr 20 = nonce[63:32], addr 21 = nonce[31:0].
- WR_RUN: addr 22, data = {pad_first, pad_last, 13'b0, halt=0, test, run=1}.
- Write-phase timing: 19 writes on 19 consecutive cycles; a 3-bit index counter wraps per group.
- WAIT_IRQ: idle bus; on irq=1 go to RD.
- RD: back-to-back reads of addr 22, 0, 1, 2 on 4 consecutive cycles.
  - The CTL read clears the IRQ and its data is discarded.
  - Capture solution[31:0], solution[63:32] and status one cycle after the corresponding read.
  - The final capture occurs in the cycle after the last read, then go to WR_STOP.
- WR_STOP: single write to addr 22, data = {pad_first, pad_last, 16'b0} (run=0), then go to RESULT.
- RESULT:
  - res_valid=1 with the res_* fields held stable.
  - On res_ready, drop res_valid and return to IDLE.
  - res_ready has no effect outside RESULT.
- Abort:
  - abort is sampled in every state except IDLE, WR_STOP and RESULT.
  - The current single-cycle transfer completes; if a read is pending, its capture is dropped.
  - Next cycle: write addr 22 with halt=1, run=0, i.e. {pad_first, pad_last, 13'b0, 3'b100}, then go to RESULT with res_aborted=1, res_found=0 and solution/status=0.
  - abort in IDLE: no effect and no bus activity.
- An irq=1 arriving in the same cycle as abort: abort wins.
- Asynchronous reset mid-job: bus strobes drop immediately and there is no stop write; the slave's own reset clears run.

Optional Feature:
- Macro: MINER_JOB_MASTER_TIMEOUT_EN.
- Enabled:
  - A 32-bit counter clears on entry to WAIT_IRQ and increments each cycle in that state.
  - When the count reaches TIMEOUT_CYCLES-1 without irq, take the abort path (halt write, res_aborted=1).
  - res_status[31] = 1 flags a timeout (status bits 31:24 are unused by the slave).
- Disabled: no counter is present; WAIT_IRQ waits indefinitely.

Decomposition:
- Package miner_regs_pkg holds:
  - register word addresses (SOLN 0, STAT 2, SHA3 3, HDR 4, DIFF 12, START 20, CTL 22);
  - CTL bit positions (run 0, test 1, halt 2, pad_last 23:16, pad_first 31:24);
  - status bit positions (found 0, running 1, testing 2);
  - FSM state enum.
- No sub-module: single FSM with a word-select mux and a read-capture pipeline.

Test Plan:
- Reset, then job with header=0x00..1F byte ramp, diff=all-ones, nonce=0x0000_0001_0000_0000, pads 0x06/0x80, test=1 -> 19 writes with addr 4..22 in order; addr 20 data 0x00000001, addr 21 data 0x00000000, addr 22 data 0x06800003.
- Slave model raises irq 50 cycles after the run write, solution=0xDEADBEEF_CAFEF00D, status=0x00013C41 -> reads 22,0,1,2 back-to-back; res_solution=0xDEADBEEFCAFEF00D, res_found=1; then a stop write to addr 22 with data 0x06800000.
- res_ready held low for 10 cycles in RESULT -> res_valid and data stable; job_ready stays 0 until the handshake completes.
- abort asserted during the 5th header write -> that write completes; next cycle addr 22 data 0x06800004; res_aborted=1, res_found=0.
- irq and abort asserted in the same WAIT_IRQ cycle -> halt write only, no reads issued.
- With MINER_JOB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=100, irq never raised -> halt write 100 cycles after entering WAIT_IRQ; res_aborted=1, res_status[31]=1.
